// File: rtl/lcd_capture.sv
// lcd_capture
// Captures the 2-bit pixel stream of a handheld-style LCD interface, packs
// four pixels per byte (first pixel in [7:6]) and hands the bytes to a
// consumer through a small first-word-fall-through FIFO.
//
// Line and frame boundaries are recovered from the composite sync: a short
// csync-high pulse is an hsync, a long one (>= VSYNC_MIN clocks) a vsync.
//
// Ports
//   clk        capture clock, same clock as the LCD outputs
//   rstn       asynchronous active-low reset
//   csync      composite sync
//   pvalid     pixel valid / clock gate
//   pixel      2-bit pixel shade
//   out_data   packed byte, four pixels, first pixel in [7:6]
//   out_valid  out_data valid (FIFO non-empty)
//   out_ready  consumer accepts byte
//   out_sof    out_data is the first byte of a frame
//   frame_done one-clock pulse when the last line of a frame completes
//   overflow   sticky: a byte was dropped in the current frame
//   frame_sum  16-bit additive checksum of the last completed frame
//
// Build option
//   LCD_CAPTURE_SUM_EN  enables the frame checksum accumulator; without it
//                       frame_sum is tied to zero.

module lcd_capture #(
    parameter int H_ACTIVE   = 160,
    parameter int V_ACTIVE   = 144,
    parameter int VSYNC_MIN  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        csync,
    input  logic        pvalid,
    input  logic [1:0]  pixel,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        frame_done,
    output logic        overflow,
    output logic [15:0] frame_sum
);

    localparam int RUN_W  = $clog2(VSYNC_MIN + 1);
    localparam int X_W    = $clog2(H_ACTIVE + 1);
    localparam int LINE_W = $clog2(V_ACTIVE + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {WAIT_VSYNC, WAIT_LINE, ACTIVE} state_t;

    state_t            state, state_next;
    logic              csync_q;
    logic [RUN_W-1:0]  run_len;
    logic              sync_fall, vsync_ev, hsync_ev;
    logic              capture, line_end, frame_end, last_line;
    logic [5:0]        pack;
    logic [1:0]        pix_cnt;
    logic [X_W-1:0]    x_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic [7:0]        packed_next, residual, new_byte;
    logic              make_byte;
    logic              push_pend;
    logic [7:0]        push_byte;
    logic              sof_arm;
    logic [8:0]        mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              empty, full, pop, push_ok;

    // Sync classifier: the run counter saturates at VSYNC_MIN so arbitrarily
    // long vsync pulses never wrap back into the hsync range.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            csync_q <= 1'b0;
            run_len <= '0;
        end else begin
            csync_q <= csync;
            if (!csync)
                run_len <= '0;
            else if (run_len != RUN_W'(VSYNC_MIN))
                run_len <= run_len + RUN_W'(1);
        end
    end

    assign sync_fall = csync_q && !csync;
    assign vsync_ev  = sync_fall && (run_len >= RUN_W'(VSYNC_MIN));
    assign hsync_ev  = sync_fall && !vsync_ev && (run_len != '0);
    assign last_line = (line_cnt == LINE_W'(V_ACTIVE - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= WAIT_VSYNC;
        else
            state <= state_next;
    end

    // A vsync restarts the frame from any state.
    always_comb begin
        state_next = state;
        if (vsync_ev) begin
            state_next = WAIT_LINE;
        end else begin
            case (state)
                WAIT_LINE: if (pvalid) state_next = ACTIVE;
                ACTIVE:    if (hsync_ev) state_next = last_line ? WAIT_VSYNC : WAIT_LINE;
                default:   state_next = state;
            endcase
        end
    end

    // Pixels are ignored on the cycle that terminates a line or a frame.
    always_comb begin
        capture   = 1'b0;
        line_end  = 1'b0;
        frame_end = 1'b0;
        if (!vsync_ev) begin
            case (state)
                WAIT_LINE: capture = pvalid;
                ACTIVE: begin
                    if (hsync_ev) begin
                        line_end  = 1'b1;
                        frame_end = last_line;
                    end else begin
                        capture = pvalid && (x_cnt < X_W'(H_ACTIVE));
                    end
                end
                default: capture = 1'b0;
            endcase
        end
    end

    // Only the three previous pixels need storing; the fourth completes the byte.
    assign packed_next = {pack, pixel};

    always_comb begin
        case (pix_cnt)
            2'd1:    residual = {pack[1:0], 6'b0};
            2'd2:    residual = {pack[3:0], 4'b0};
            2'd3:    residual = {pack, 2'b0};
            default: residual = 8'h00;
        endcase
    end

    assign make_byte = (capture && (pix_cnt == 2'd3)) || (line_end && (pix_cnt != 2'd0));
    assign new_byte  = line_end ? residual : packed_next;

    // Completed bytes are staged one cycle before entering the FIFO.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pack      <= '0;
            pix_cnt   <= '0;
            x_cnt     <= '0;
            line_cnt  <= '0;
            push_pend <= 1'b0;
            push_byte <= '0;
        end else begin
            push_pend <= make_byte;
            if (make_byte)
                push_byte <= new_byte;
            if (vsync_ev) begin
                pack     <= '0;
                pix_cnt  <= '0;
                x_cnt    <= '0;
                line_cnt <= '0;
            end else if (line_end) begin
                pack     <= '0;
                pix_cnt  <= '0;
                x_cnt    <= '0;
                line_cnt <= line_cnt + LINE_W'(1);
            end else if (capture) begin
                pack    <= packed_next[5:0];
                pix_cnt <= pix_cnt + 2'd1;
                x_cnt   <= x_cnt + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            frame_done <= 1'b0;
        else
            frame_done <= frame_end;
    end

    // A byte staged on the vsync cycle still belongs to the old frame, so
    // vsync wins over a simultaneous push/drop for both flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sof_arm  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (vsync_ev)
                sof_arm <= 1'b1;
            else if (push_pend)
                sof_arm <= 1'b0;
            if (vsync_ev)
                overflow <= 1'b0;
            else if (push_pend && !push_ok)
                overflow <= 1'b1;
        end
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop     = out_valid && out_ready;
    assign push_ok = push_pend && (!full || pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[PTR_W-1:0]] <= {sof_arm, push_byte};
    end

    // Storage is not reset, so the head entry is masked while empty.
    assign out_valid           = !empty;
    assign {out_sof, out_data} = out_valid ? mem[rd_ptr[PTR_W-1:0]] : 9'd0;

`ifdef LCD_CAPTURE_SUM_EN
    logic [15:0] sum_acc, sum_q;

    // Dropped bytes are still summed; the residual byte of the last line is
    // folded in on the same cycle the frame completes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_acc <= '0;
            sum_q   <= '0;
        end else begin
            if (vsync_ev)
                sum_acc <= '0;
            else if (make_byte)
                sum_acc <= sum_acc + {8'h00, new_byte};
            if (frame_end)
                sum_q <= sum_acc + (make_byte ? {8'h00, new_byte} : 16'h0000);
        end
    end

    assign frame_sum = sum_q;
`else
    assign frame_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_capture.sv
// tb_lcd_capture
// Randomised scoreboard bench for lcd_capture. Each line's pixels are drawn
// up front, turned into expected bytes by plain base-4 arithmetic and queued;
// an independent monitor pops the queue whenever the DUT hands over a byte.
// Small parameters keep frames short. Works with or without
// LCD_CAPTURE_SUM_EN defined.

module tb_lcd_capture;

    localparam int H     = 16;
    localparam int V     = 4;
    localparam int VMIN  = 8;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        csync = 1'b0;
    logic        pvalid = 1'b0;
    logic [1:0]  pixel = 2'd0;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sof;
    logic        frame_done;
    logic        overflow;
    logic [15:0] frame_sum;

    int          compared = 0;
    int          mismatched = 0;
    logic [8:0]  exp_q[$];
    int          line_px[$];
    int          exp_done = 0;
    int          done_seen = 0;
    logic [15:0] exp_sum = 16'h0000;
    logic [15:0] sum_model = 16'h0000;
    bit          sof_pending = 1'b0;
    int          exp_keep = 0;
    int          ready_mode = 1;
    int          low_run = 0;

    lcd_capture #(
        .H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_MIN(VMIN), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn), .csync(csync), .pvalid(pvalid), .pixel(pixel),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .frame_done(frame_done), .overflow(overflow),
        .frame_sum(frame_sum)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Consumer: mode 0 stalls, 1 always ready, 2 random but never low three
    // cycles running, so the FIFO cannot fill during random frames.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) begin
            out_ready = 1'b0;
        end else if (ready_mode == 1) begin
            out_ready = 1'b1;
        end else if (low_run >= 2 || $urandom_range(0, 1) == 1) begin
            out_ready = 1'b1;
            low_run = 0;
        end else begin
            out_ready = 1'b0;
            low_run++;
        end
    end

    // Monitor: compares every handed-over byte, checks hold-while-stalled
    // and that frame_done is a single-cycle pulse.
    logic [8:0] last_word = 9'd0;
    bit         last_stall = 1'b0;
    bit         last_done = 1'b0;
    always @(negedge clk) begin
        if (rstn) begin
            if (last_stall)
                checkOutput("hold", {out_valid, out_sof, out_data}, {1'b1, last_word});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected byte: got 0x%0h sof %0d, expected none", out_data, out_sof);
                end else begin
                    checkOutput("byte", {out_sof, out_data}, exp_q.pop_front());
                end
            end
            last_stall = out_valid && !out_ready;
            last_word  = {out_sof, out_data};
            if (frame_done) begin
                done_seen++;
                if (last_done) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL frame_done width: got 2+ cycles, expected 1");
                end
            end
            last_done = frame_done;
        end else begin
            last_stall = 1'b0;
            last_done  = 1'b0;
        end
    end

    task automatic cycle(input logic cs, input logic pv, input logic [1:0] px);
        csync  = cs;
        pvalid = pv;
        pixel  = px;
        @(posedge clk);
        #1;
    endtask

    task automatic sendSync(input int run);
        for (int i = 0; i < run; i++) cycle(1'b1, 1'b0, 2'd0);
        cycle(1'b0, 1'b0, 2'd0);
        cycle(1'b0, 1'b0, 2'd0);
    endtask

    task automatic randomLine(input bit full);
        int n;
        line_px.delete();
        n = full ? H : $urandom_range(1, H + 5);
        for (int i = 0; i < n; i++) line_px.push_back($urandom_range(0, 3));
    endtask

    // Model: the first H pixels of the line read as base-4 digits, four per
    // byte, short final group padded with zero digits.
    task automatic applyStimulus(input bit sync_after);
        int n;
        int val;
        n = (line_px.size() < H) ? line_px.size() : H;
        for (int g = 0; g < n; g += 4) begin
            val = 0;
            for (int k = 0; k < 4; k++) val = val * 4 + ((g + k < n) ? line_px[g + k] : 0);
            sum_model += 16'(val);
            if (exp_keep != 0) begin
                exp_q.push_back({sof_pending, 8'(val)});
                sof_pending = 1'b0;
                if (exp_keep > 0) exp_keep--;
            end
        end
        foreach (line_px[i]) begin
            if ($urandom_range(0, 3) == 0) cycle(1'b0, 1'b0, 2'd0);
            cycle(1'b0, 1'b1, 2'(line_px[i]));
        end
        cycle(1'b0, 1'b0, 2'd0);
        if (sync_after) sendSync($urandom_range(1, VMIN - 1));
    endtask

    task automatic startFrame(input int vrun, input int keep);
        sendSync(vrun);
        sof_pending = 1'b1;
        exp_keep    = keep;
        sum_model   = 16'h0000;
    endtask

    task automatic endFrame();
        exp_done++;
`ifdef LCD_CAPTURE_SUM_EN
        exp_sum = sum_model;
`else
        exp_sum = 16'h0000;
`endif
    endtask

    task automatic waitDrain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain", exp_q.size(), 0);
        repeat (4) cycle(1'b0, 1'b0, 2'd0);
    endtask

    task automatic checkFrameState(input logic exp_ovf);
        checkOutput("frame_done count", done_seen, exp_done);
        checkOutput("frame_sum", frame_sum, exp_sum);
        checkOutput("overflow", overflow, exp_ovf);
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_data", out_data, 0);
        checkOutput("reset out_sof", out_sof, 0);
        checkOutput("reset frame_done", frame_done, 0);
        checkOutput("reset overflow", overflow, 0);
        checkOutput("reset frame_sum", frame_sum, 0);
        rstn = 1'b1;
        ready_mode = 1;
        repeat (2) cycle(1'b0, 1'b0, 2'd0);

        // A pulse one short of vsync is not a frame start.
        exp_keep = 0;
        sendSync(VMIN - 1);
        randomLine(1'b0);
        applyStimulus(1'b1);
        repeat (10) cycle(1'b0, 1'b0, 2'd0);
        checkOutput("no capture before vsync", out_valid, 0);

        // Directed first line 3,2,1,0,3,3 -> E4, F0; exact-threshold vsync.
        startFrame(VMIN, -1);
        line_px = '{3, 2, 1, 0, 3, 3};
        applyStimulus(1'b1);
        for (int l = 1; l < V; l++) begin
            randomLine(1'b0);
            applyStimulus(1'b1);
        end
        endFrame();
        waitDrain();
        checkFrameState(1'b0);

        // Random frames with a back-pressuring consumer; one very long vsync.
        ready_mode = 2;
        for (int f = 0; f < 6; f++) begin
            startFrame((f == 2) ? 2 * VMIN : VMIN + $urandom_range(0, 4), -1);
            for (int l = 0; l < V; l++) begin
                randomLine(1'b0);
                applyStimulus(1'b1);
            end
            endFrame();
            waitDrain();
            checkFrameState(1'b0);
        end

        // Frame aborted by vsync after two lines: no frame_done, sum held.
        startFrame(VMIN, -1);
        for (int l = 0; l < 2; l++) begin
            randomLine(1'b0);
            applyStimulus(1'b1);
        end
        startFrame(VMIN + 1, -1);
        for (int l = 0; l < V; l++) begin
            randomLine(1'b0);
            applyStimulus(1'b1);
        end
        endFrame();
        waitDrain();
        checkFrameState(1'b0);

        // Stalled consumer: 16 bytes produced, only DEPTH survive.
        ready_mode = 0;
        repeat (2) cycle(1'b0, 1'b0, 2'd0);
        startFrame(VMIN, DEPTH);
        for (int l = 0; l < V; l++) begin
            randomLine(1'b1);
            applyStimulus(1'b1);
        end
        endFrame();
        repeat (4) cycle(1'b0, 1'b0, 2'd0);
        checkOutput("overflow set", overflow, 1);
        checkOutput("full valid", out_valid, 1);
        ready_mode = 1;
        waitDrain();
        checkFrameState(1'b1);
        sendSync(VMIN);
        checkOutput("overflow cleared by vsync", overflow, 0);

        // Reset mid-frame with bytes queued.
        ready_mode = 0;
        startFrame(VMIN, 0);
        randomLine(1'b1);
        applyStimulus(1'b1);
        line_px.delete();
        for (int i = 0; i < 12; i++) line_px.push_back($urandom_range(0, 3));
        applyStimulus(1'b0);
        repeat (2) cycle(1'b0, 1'b0, 2'd0);
        checkOutput("queued before reset", out_valid, 1);
        #2 rstn = 1'b0;
        #1;
        checkOutput("reset flush out_valid", out_valid, 0);
        checkOutput("reset flush out_data", out_data, 0);
        checkOutput("reset frame_sum", frame_sum, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        exp_sum = 16'h0000;
        ready_mode = 1;
        exp_keep = 0;
        for (int l = 0; l < 2; l++) begin
            randomLine(1'b1);
            applyStimulus(1'b1);
        end
        repeat (10) cycle(1'b0, 1'b0, 2'd0);
        checkOutput("no bytes after reset", out_valid, 0);
        checkFrameState(1'b0);

        // Capture resumes after a vsync.
        ready_mode = 2;
        startFrame(VMIN + 2, -1);
        for (int l = 0; l < V; l++) begin
            randomLine(1'b0);
            applyStimulus(1'b1);
        end
        endFrame();
        waitDrain();
        checkFrameState(1'b0);

        checkOutput("leftover expected", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
